// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the LEGv8 load/store unit.
// Op codes 5..7 are reserved and reported as illegal.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LDUR   = 3'd0,
    OP_LDURSW = 3'd1,
    OP_LDURH  = 3'd2,
    OP_LDURB  = 3'd3,
    OP_STURW  = 3'd4
  } lsu_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } lsu_state_e;

  function automatic logic is_load(input logic [2:0] op);
    return op <= 3'd3;
  endfunction

  function automatic logic is_legal(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

endpackage

// File: rtl/load_store_unit_extender.sv
// Combinational size/sign extension of the raw 64-bit memory word.
// Any non-load op passes the word through unchanged.
module load_extender
  import lsu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [63:0] raw_i,
  output logic [63:0] ext_o
);

  always_comb begin
    ext_o = raw_i;
    case (lsu_op_e'(op_i))
      OP_LDURSW: ext_o = {{32{raw_i[31]}}, raw_i[31:0]};
      OP_LDURH:  ext_o = {48'd0, raw_i[15:0]};
      OP_LDURB:  ext_o = {56'd0, raw_i[7:0]};
      default:   ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage in front of Data_Memory: one request at a time,
// flags/address/data held for MEM_LAT cycles, load results returned via valid/ready.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 8,
  parameter int TAG_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [TAG_W-1:0]  req_rd,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_data,
  output logic [TAG_W-1:0]  resp_rd,
  output logic              illegal_op,
  output logic              mem_read_data_flag,
  output logic              mem_write_data_flag,
  output logic [ADDR_W-1:0] mem_address_of_data,
  output logic [31:0]       mem_data_to_write,
  input  logic [63:0]       mem_data_read_out
);

  localparam int CNT_W = 4;

  lsu_state_e        state_q;
  logic [2:0]        op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              flushed_q;
  logic              req_ready_q, resp_valid_q, illegal_q;
  logic              rd_flag_q, wr_flag_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [63:0]       resp_data_q;
  logic [TAG_W-1:0]  resp_rd_q;
  logic [63:0]       ext_d;

  // The write port is 32 bits wide, so the upper store half never leaves the unit.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^req_wdata[63:32];

  load_extender u_ext (
    .op_i  (op_q),
    .raw_i (mem_data_read_out),
    .ext_o (ext_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      cnt_q        <= '0;
      flushed_q    <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
      rd_flag_q    <= 1'b0;
      wr_flag_q    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && !flush) begin
            if (is_legal(req_op)) begin
              op_q        <= req_op;
              addr_q      <= req_addr;
              wdata_q     <= req_wdata[31:0];
              resp_rd_q   <= req_rd;
              cnt_q       <= CNT_W'(MEM_LAT - 1);
              flushed_q   <= 1'b0;
              rd_flag_q   <= is_load(req_op);
              wr_flag_q   <= !is_load(req_op);
              req_ready_q <= 1'b0;
              state_q     <= S_ACCESS;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          // A flush seen at any point of a load's access kills its response.
          if (flush && is_load(op_q)) flushed_q <= 1'b1;
          if (cnt_q == '0) begin
            rd_flag_q <= 1'b0;
            wr_flag_q <= 1'b0;
            if (is_load(op_q) && !(flushed_q || flush)) begin
              resp_data_q  <= ext_d;
              resp_valid_q <= 1'b1;
              state_q      <= S_RESP;
            end else begin
              req_ready_q <= 1'b1;
              state_q     <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (flush || resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready           = req_ready_q;
  assign resp_valid          = resp_valid_q;
  assign resp_data           = resp_data_q;
  assign resp_rd             = resp_rd_q;
  assign illegal_op          = illegal_q;
  assign mem_read_data_flag  = rd_flag_q;
  assign mem_write_data_flag = wr_flag_q;
  assign mem_address_of_data = addr_q;
  assign mem_data_to_write   = wdata_q;

endmodule
